sum_window_accumulator: RTL and testbench
=========================================

// Module: sum_window_accumulator
// PURPOSE
//  Downstream consumer of the registered 3-bit operand-sum stream (a+b of two 2-bit values, 0..6).
//  Accumulates WINDOW accepted samples, then presents the window total on a valid/ready output port.
//  Applies input back-pressure while a result is pending. Sits between the sum stage and the result sink.
// PARAMETERS
//  IN_W    3   width of incoming sum sample
//  ACC_W   6   accumulator / result width; wraps modulo 2^ACC_W unless ACC_SAT_EN
//  WINDOW  16  samples per window; legal range 2..2^CNT_W-1
//  CNT_W   5   sample-counter width
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  clear      in   1      synchronous abort: drop partial window / pending result
//  in_sum     in   IN_W   sample from sum stage
//  in_valid   in   1      in_sum valid this cycle
//  in_ready   out  1      block can accept a sample
//  acc_out    out  ACC_W  window total, stable while out_valid
//  out_valid  out  1      acc_out holds a completed window
//  out_ready  in   1      sink accepts acc_out
//  ovf        out  1      sticky: some add in the current window exceeded 2^ACC_W-1
// BEHAVIOUR
//  - Reset (async): state=IDLE, acc=0, count=0, acc_out=0, out_valid=0, ovf=0; in_ready=1 once reset deasserts.
//  - Accept = in_valid & in_ready, sampled on the rising edge. in_ready = (state!=HOLD) (combinational from state).
//  - FSM: IDLE  --accept--> ACCUM   (acc<=in_sum, count<=1)
//         ACCUM --accept, count==WINDOW-1--> HOLD (acc_out<=acc+in_sum, out_valid<=1)
//         ACCUM --accept, otherwise--> ACCUM (acc<=acc+in_sum, count<=count+1)
//         HOLD  --out_valid & out_ready--> IDLE (acc<=0, count<=0, out_valid<=0, ovf<=0)
//  - Latency: out_valid rises the cycle after the WINDOW-th accept; no accepts possible in HOLD
//    (one bubble cycle per window minimum, plus any sink stall).
//  - acc_out and ovf held constant while out_valid=1 and out_ready=0.
//  - Adds are ACC_W+1 wide; carry out sets ovf. Without ACC_SAT_EN the result wraps mod 2^ACC_W.
//  - in_valid without accept in ACCUM/IDLE: no state change. in_sum ignored when in_valid=0.
//  - clear: highest priority over accept and output handshake in any state -> IDLE, acc=0, count=0,
//    out_valid=0, ovf=0; a sample presented in the same cycle is dropped; acc_out keeps last value.
//  - Reset asserted mid-window or in HOLD discards everything immediately (async), no output produced.
// CONFIGURATION
//  `ACC_SAT_EN defined: each add clamps to 2^ACC_W-1 on carry-out; ovf still set; acc_out never wraps.
//  `ACC_SAT_EN undefined: modulo-2^ACC_W wrap; ovf is the only overflow indication. Ports identical.
// STRUCTURE
//  - Shared header sum_acc_defs.vh: FSM state encodings (ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2),
//    default IN_W/ACC_W/WINDOW values, shared with the sum stage and its bench.
//  - One sub-module: sum_acc_add (ACC_W-bit + IN_W-bit adder, zero-extends sample, returns sum and
//    carry; holds the `ACC_SAT_EN clamp). Counter and FSM stay in the top module.
// TESTING
//  1 Reset: assert reset mid-cycle -> all outputs 0 immediately, in_ready=1 after release.
//  2 16 back-to-back samples of 3 -> out_valid 1 cycle after 16th accept, acc_out=48, ovf=0.
//  3 16 samples of 6 (sum 96): no SAT -> acc_out=32, ovf=1; with `ACC_SAT_EN -> acc_out=63, ovf=1.
//  4 out_ready held 0 for 5 cycles after out_valid -> acc_out/ovf stable, in_ready=0, in_valid
//    samples not consumed; out_ready=1 -> next cycle IDLE, new window starts cleanly at 0.
//  5 clear after 7 samples with in_valid=1 same cycle -> count=0, sample dropped; next 16 samples
//    of 1 -> acc_out=16.
//  6 Gappy input (in_valid toggling 1010...) of 16 samples of 2 -> acc_out=32, no extra/lost samples.

Source files
------------

// File: rtl/sum_window_accumulator_pkg.sv
// rtl/sum_window_accumulator_pkg.sv - shared FSM encodings and default widths for the window accumulator
package sum_window_accumulator_pkg;

    localparam int IN_W_DEF   = 3;
    localparam int ACC_W_DEF  = 6;
    localparam int WINDOW_DEF = 16;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/sum_window_accumulator_if.sv
// rtl/sum_window_accumulator_if.sv - sample input and window-result handshake bundle
interface sum_window_accumulator_if #(
    parameter int IN_W  = 3,
    parameter int ACC_W = 6
);
    logic [IN_W-1:0]  in_sum;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;

    modport master (
        output in_sum, in_valid, out_ready,
        input  in_ready, acc_out, out_valid, ovf
    );

    modport slave (
        input  in_sum, in_valid, out_ready,
        output in_ready, acc_out, out_valid, ovf
    );
endinterface

// File: rtl/sum_window_accumulator_add.sv
// rtl/sum_window_accumulator_add.sv - accumulator adder with carry-out; clamps on carry when ACC_SAT_EN is defined
module sum_acc_add #(
    parameter int IN_W  = 3,
    parameter int ACC_W = 6
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [IN_W-1:0]  sample_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);
    logic [ACC_W:0] wide_sum;

    assign wide_sum = {1'b0, acc_i} + {{(ACC_W+1-IN_W){1'b0}}, sample_i};
    assign carry_o  = wide_sum[ACC_W];

`ifdef ACC_SAT_EN
    assign sum_o = carry_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
    assign sum_o = wide_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_window_accumulator.sv
// rtl/sum_window_accumulator.sv - sums WINDOW accepted samples and holds the total until the sink takes it (ACC_SAT_EN selects clamping)
module sum_window_accumulator
    import sum_window_accumulator_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int WINDOW = WINDOW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    sum_window_accumulator_if.slave bus
);
    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;

    logic             in_ready;
    logic             accept;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    sum_acc_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i    (acc_q),
        .sample_i (bus.in_sum),
        .sum_o    (add_sum),
        .carry_o  (add_carry)
    );

    assign in_ready      = (state_q != ST_HOLD);
    assign accept        = bus.in_valid & in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.acc_out   = acc_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            acc_out_q   <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            acc_out_q   <= acc_out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        acc_out_d   = acc_out_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;

        // clear beats both handshakes; acc_out deliberately keeps the last window total
        if (clear) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_ACCUM;
                        acc_d   = ACC_W'(bus.in_sum);
                        count_d = CNT_W'(1);
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        ovf_d = ovf_q | add_carry;
                        if (count_q == CNT_W'(WINDOW - 1)) begin
                            state_d     = ST_HOLD;
                            acc_out_d   = add_sum;
                            out_valid_d = 1'b1;
                        end else begin
                            acc_d   = add_sum;
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_d     = ST_IDLE;
                        acc_d       = '0;
                        count_d     = '0;
                        out_valid_d = 1'b0;
                        ovf_d       = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_window_accumulator.sv
// tb/tb_sum_window_accumulator.sv - directed table-driven bench for sum_window_accumulator (honours ACC_SAT_EN)
module tb_sum_window_accumulator;
    localparam int WIN = 16;
`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic reset;
    logic clear;
    int   n_cmp;
    int   n_fail;

    sum_window_accumulator_if #(.IN_W(3), .ACC_W(6)) bus ();

    sum_window_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit gappy;
        int exp_acc;
        bit exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Feeds WIN samples of val starting at a negedge, then checks the held result.
    task automatic run_window(input string name, input int val, input bit gappy,
                              input int exp_acc, input bit exp_ovf);
        for (int i = 0; i < WIN; i++) begin
            if (gappy) begin
                bus.in_valid = 1'b0;
                bus.in_sum   = 3'd7;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_sum   = 3'(val);
            if (i == WIN - 1) begin
                check({name, " out_valid before last"}, 32'(bus.out_valid), 0);
                check({name, " in_ready before last"}, 32'(bus.in_ready), 1);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check({name, " out_valid"}, 32'(bus.out_valid), 1);
        check({name, " acc_out"}, 32'(bus.acc_out), 32'(exp_acc));
        check({name, " ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        check({name, " in_ready hold"}, 32'(bus.in_ready), 0);
    endtask

    task automatic drain(input string name);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, " drained out_valid"}, 32'(bus.out_valid), 0);
        check({name, " drained in_ready"}, 32'(bus.in_ready), 1);
        check({name, " drained ovf"}, 32'(bus.ovf), 0);
    endtask

    vec_t vecs[6];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vecs[0] = '{val: 3, gappy: 1'b0, exp_acc: 48, exp_ovf: 1'b0};
        vecs[1] = '{val: 6, gappy: 1'b0, exp_acc: SAT ? 63 : 32, exp_ovf: 1'b1};
        vecs[2] = '{val: 2, gappy: 1'b1, exp_acc: 32, exp_ovf: 1'b0};
        vecs[3] = '{val: 4, gappy: 1'b1, exp_acc: SAT ? 63 : 0, exp_ovf: 1'b1};
        vecs[4] = '{val: 0, gappy: 1'b0, exp_acc: 0, exp_ovf: 1'b0};
        vecs[5] = '{val: 1, gappy: 1'b0, exp_acc: 16, exp_ovf: 1'b0};

        reset         = 1'b1;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 0);
        check("reset acc_out", 32'(bus.acc_out), 0);
        check("reset ovf", 32'(bus.ovf), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 32'(bus.in_ready), 1);

        for (int v = 0; v < 6; v++) begin
            run_window($sformatf("vec%0d", v), vecs[v].val, vecs[v].gappy,
                       vecs[v].exp_acc, vecs[v].exp_ovf);
            drain($sformatf("vec%0d", v));
        end

        // sink stall: result and ovf frozen, offered samples not consumed
        run_window("stall", 6, 1'b0, SAT ? 63 : 32, 1'b1);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 3'd5;
            @(negedge clk);
            check("stall out_valid", 32'(bus.out_valid), 1);
            check("stall acc_out", 32'(bus.acc_out), SAT ? 63 : 32);
            check("stall ovf", 32'(bus.ovf), 1);
            check("stall in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        drain("stall");
        run_window("after stall", 1, 1'b0, 16, 1'b0);
        drain("after stall");

        // clear mid-window drops the partial sum and the concurrent sample
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 3'd4;
            @(negedge clk);
        end
        clear = 1'b1;
        @(negedge clk);
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("clear out_valid", 32'(bus.out_valid), 0);
        check("clear acc_out kept", 32'(bus.acc_out), 16);
        check("clear in_ready", 32'(bus.in_ready), 1);
        run_window("after clear", 1, 1'b0, 16, 1'b0);
        drain("after clear");

        // clear while holding a result
        run_window("hold clear", 2, 1'b0, 32, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("hold clear out_valid", 32'(bus.out_valid), 0);
        check("hold clear acc_out kept", 32'(bus.acc_out), 32);
        check("hold clear in_ready", 32'(bus.in_ready), 1);

        // async reset while holding an overflowed result
        run_window("pre reset", 6, 1'b0, SAT ? 63 : 32, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async reset out_valid", 32'(bus.out_valid), 0);
        check("async reset acc_out", 32'(bus.acc_out), 0);
        check("async reset ovf", 32'(bus.ovf), 0);
        check("async reset in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        // async reset mid-window, then a clean window
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 3'd6;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid reset out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_window("after reset", 2, 1'b0, 32, 1'b0);
        drain("after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
